// File: rtl/capsense_events_if.sv
// capsense_events_if: event handshake between the CapSense event generator and
// its consumer (LED/UI controller). The producer drives the FIFO head (valid,
// code, button index) and the consumer answers with ready.
interface capsense_events_if #(
  parameter int IDXW = 2
) ();
  logic            evt_valid_o;
  logic            evt_ready_i;
  logic [1:0]      evt_code_o;
  logic [IDXW-1:0] evt_idx_o;

  modport master (
    output evt_valid_o,
    output evt_code_o,
    output evt_idx_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_code_o,
    input  evt_idx_o,
    output evt_ready_i
  );
endinterface

// File: rtl/capsense_events.sv
// capsense_events: per-button debounce and press/release/long event generator.
// One CapSense snapshot is scanned one button per cycle; a button flips its
// stable level after DEB_SAMPLES consecutive disagreeing samples. Events go into
// a FIFO_DEPTH-entry FIFO whose head is presented through capsense_events_if.
// Optional feature: define CAPSENSE_EVT_LONG_EN to build the long-press logic
// (code 11 after LONG_SAMPLES agreeing samples while stable-pressed).
module capsense_events #(
  parameter int N            = 4,
  parameter int DEB_SAMPLES  = 3,
  parameter int LONG_SAMPLES = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_valid_i,
  input  logic [N-1:0]     buttons_i,
  output logic [N-1:0]     stable_o,
  output logic             busy_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i,
  capsense_events_if.master evt
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int EW   = 2 + IDXW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Pack an event into one FIFO word: code in the top two bits, index below.
  function automatic logic [EW-1:0] pack_evt(input logic [1:0] code, input logic [IDXW-1:0] idx);
    return {code, idx};
  endfunction

  // Scanner state
  state_t          state_r;
  logic            busy_r;
  logic [IDXW-1:0] idx_r;
  logic [N-1:0]    snap_r;
  logic [N-1:0]    pend_r;
  logic            pend_valid_r;

  // Per-button debounce state
  logic [N-1:0]    stable_r;
  logic [3:0]      dcnt_r [N];
`ifdef CAPSENSE_EVT_LONG_EN
  logic [7:0]      hold_r [N];
  logic [N-1:0]    long_done_r;
  logic [7:0]      hold_next_s;
  logic            ld_next_s;
`endif

  // Visit results for the button at idx_r
  logic            raw_s;
  logic            cur_stable_s;
  logic [4:0]      dcnt_inc_s;
  logic [3:0]      dcnt_next_s;
  logic            flip_s;
  logic            push_s;
  logic [1:0]      push_code_s;

  // FIFO state
  logic [EW-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]   rd_r;
  logic [PW-1:0]   wr_r;
  logic [CW-1:0]   cnt_r;
  logic            evt_valid_r;
  logic [1:0]      evt_code_r;
  logic [IDXW-1:0] evt_idx_r;
  logic            overflow_r;

  logic            pop_s;
  logic            full_s;
  logic            acc_s;
  logic            drop_s;
  logic [EW-1:0]   push_data_s;
  logic [PW-1:0]   rd_next_s;
  logic [CW-1:0]   cnt_next_s;
  logic [CW-1:0]   left_s;
  logic            head_valid_next_s;
  logic [EW-1:0]   head_next_s;

  // Debounce decision for the button currently being visited.
  always_comb begin
    raw_s        = snap_r[idx_r];
    cur_stable_s = stable_r[idx_r];
    dcnt_inc_s   = {1'b0, dcnt_r[idx_r]} + 5'd1;
    dcnt_next_s  = dcnt_r[idx_r];
    flip_s       = 1'b0;
    push_s       = 1'b0;
    push_code_s  = 2'b00;
`ifdef CAPSENSE_EVT_LONG_EN
    hold_next_s  = hold_r[idx_r];
    ld_next_s    = long_done_r[idx_r];
`endif
    if (busy_r) begin
      if (raw_s != cur_stable_s) begin
        if (dcnt_inc_s == 5'(DEB_SAMPLES)) begin
          flip_s      = 1'b1;
          push_s      = 1'b1;
          push_code_s = raw_s ? 2'b01 : 2'b10;
          dcnt_next_s = 4'd0;
`ifdef CAPSENSE_EVT_LONG_EN
          hold_next_s = 8'd0;
          ld_next_s   = 1'b0;
`endif
        end else begin
          dcnt_next_s = dcnt_inc_s[3:0];
        end
      end else begin
        dcnt_next_s = 4'd0;
`ifdef CAPSENSE_EVT_LONG_EN
        if (cur_stable_s && !long_done_r[idx_r]) begin
          hold_next_s = (hold_r[idx_r] == 8'hFF) ? 8'hFF : hold_r[idx_r] + 8'd1;
          if ({1'b0, hold_r[idx_r]} + 9'd1 == 9'(LONG_SAMPLES)) begin
            push_s      = 1'b1;
            push_code_s = 2'b11;
            ld_next_s   = 1'b1;
          end else begin
            push_s      = 1'b0;
          end
        end else begin
          hold_next_s = hold_r[idx_r];
        end
`endif
      end
    end else begin
      dcnt_next_s = dcnt_r[idx_r];
    end
  end

  // Scanner FSM plus per-button state update on each visit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      idx_r        <= '0;
      snap_r       <= '0;
      pend_r       <= '0;
      pend_valid_r <= 1'b0;
      stable_r     <= '0;
      for (int i = 0; i < N; i++) begin
        dcnt_r[i] <= 4'd0;
`ifdef CAPSENSE_EVT_LONG_EN
        hold_r[i] <= 8'd0;
`endif
      end
`ifdef CAPSENSE_EVT_LONG_EN
      long_done_r  <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (sample_valid_i) begin
            snap_r  <= buttons_i;
            idx_r   <= '0;
            state_r <= SCAN;
            busy_r  <= 1'b1;
          end
        end
        SCAN: begin
          if (idx_r == IDXW'(N - 1)) begin
            idx_r <= '0;
            // A strobe on the last visit is newer than anything pending.
            if (sample_valid_i) begin
              snap_r       <= buttons_i;
              pend_valid_r <= 1'b0;
            end else if (pend_valid_r) begin
              snap_r       <= pend_r;
              pend_valid_r <= 1'b0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            idx_r <= idx_r + IDXW'(1);
            if (sample_valid_i) begin
              pend_r       <= buttons_i;
              pend_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase

      if (busy_r) begin
        dcnt_r[idx_r] <= dcnt_next_s;
        if (flip_s) begin
          stable_r[idx_r] <= raw_s;
        end
`ifdef CAPSENSE_EVT_LONG_EN
        hold_r[idx_r]      <= hold_next_s;
        long_done_r[idx_r] <= ld_next_s;
`endif
      end
    end
  end

  // FIFO bookkeeping and next head; a full FIFO still accepts when popping.
  always_comb begin
    pop_s        = evt_valid_r && evt.evt_ready_i;
    full_s       = (cnt_r == CW'(FIFO_DEPTH));
    acc_s        = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    push_data_s  = pack_evt(push_code_s, idx_r);
    rd_next_s    = pop_s ? rd_r + PW'(1) : rd_r;
    cnt_next_s   = cnt_r + CW'(acc_s) - CW'(pop_s);
    left_s       = cnt_r - CW'(pop_s);
    if (cnt_next_s == CW'(0)) begin
      head_valid_next_s = 1'b0;
      head_next_s       = '0;
    end else if (left_s == CW'(0)) begin
      head_valid_next_s = 1'b1;
      head_next_s       = push_data_s;
    end else begin
      head_valid_next_s = 1'b1;
      head_next_s       = mem_r[rd_next_s];
    end
  end

  // FIFO storage, pointers, registered head and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_r        <= '0;
      wr_r        <= '0;
      cnt_r       <= '0;
      evt_valid_r <= 1'b0;
      evt_code_r  <= 2'b00;
      evt_idx_r   <= '0;
      overflow_r  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (acc_s) begin
        mem_r[wr_r] <= push_data_s;
        wr_r        <= wr_r + PW'(1);
      end
      rd_r        <= rd_next_s;
      cnt_r       <= cnt_next_s;
      evt_valid_r <= head_valid_next_s;
      evt_code_r  <= head_next_s[EW-1 -: 2];
      evt_idx_r   <= head_next_s[IDXW-1:0];
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign stable_o        = stable_r;
  assign busy_o          = busy_r;
  assign overflow_o      = overflow_r;
  assign evt.evt_valid_o = evt_valid_r;
  assign evt.evt_code_o  = evt_code_r;
  assign evt.evt_idx_o   = evt_idx_r;

endmodule
